// File: rtl/dcache_pkg.sv
// Shared geometry, state encodings and byte-select helper for the direct-mapped data cache.
package dcache_pkg;

    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int LINES    = 8;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BACK,
        MEM_READ
    } state_e;

    typedef enum logic {
        REQ,
        GAP
    } phase_e;

    function automatic logic [7:0] pick_byte(input logic [31:0] line, input logic [OFFSET_W-1:0] sel);
        return line[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage for 8 lines of 4 bytes, with a combinational lookup
// on the presented index and separate CPU-write, fill and tag-update ports.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [INDEX_W-1:0]  index_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic [OFFSET_W-1:0] offset_i,
    input  logic                cpu_we_i,
    input  logic [7:0]          cpu_wdata_i,
    input  logic                fill_we_i,
    input  logic [OFFSET_W-1:0] fill_beat_i,
    input  logic [7:0]          fill_data_i,
    input  logic                tag_we_i,
    output logic                hit_o,
    output logic                victim_dirty_o,
    output logic [TAG_W-1:0]    victim_tag_o,
    output logic [31:0]         line_o
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '{default: '0};
            data_q  <= '{default: '0};
        end else begin
            if (cpu_we_i) begin
                data_q[index_i][{offset_i, 3'b000} +: 8] <= cpu_wdata_i;
                dirty_q[index_i] <= 1'b1;
            end
            if (fill_we_i) begin
                data_q[index_i][{fill_beat_i, 3'b000} +: 8] <= fill_data_i;
            end
            // Tag update closes a fill: the line becomes a clean copy of memory.
            if (tag_we_i) begin
                tag_q[index_i]   <= tag_i;
                valid_q[index_i] <= 1'b1;
                dirty_q[index_i] <= 1'b0;
            end
        end
    end

    assign hit_o          = valid_q[index_i] && (tag_q[index_i] == tag_i);
    assign victim_dirty_o = valid_q[index_i] && dirty_q[index_i];
    assign victim_tag_o   = tag_q[index_i];
    assign line_o         = data_q[index_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate cache: hit path, miss FSM and byte-wise memory beats.
//   state      | meaning
//   IDLE       | serve hits, detect misses
//   WRITE_BACK | 4 byte writes of the dirty victim line
//   MEM_READ   | 4 byte reads filling the line, then tag/valid update
module data_cache
    import dcache_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       busywait,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_address,
    output logic [7:0] mem_writedata,
    input  logic [7:0] mem_readdata,
    input  logic       mem_busywait
);

    state_e      state_q;
    phase_e      phase_q;
    logic [1:0]  beat_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [7:0]  mem_address_q;
    logic [7:0]  mem_writedata_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [TAG_W-1:0]   victim_tag;
    logic [31:0]        line;
    logic [1:0]         next_beat;
    logic               access, hit, victim_dirty, cpu_we, fill_we, tag_we;

    assign idx       = address[4:2];
    assign tag       = address[7:5];
    assign access    = read ^ write;
    assign next_beat = beat_q + 2'd1;

    assign busywait = (state_q != IDLE) || (access && !hit);
    assign readdata = (state_q == IDLE && read && !write && hit) ? pick_byte(line, address[1:0]) : 8'h00;
    assign cpu_we   = (state_q == IDLE) && write && !read && hit;
    assign fill_we  = (state_q == MEM_READ) && (phase_q == REQ) && !mem_busywait;
    assign tag_we   = (state_q == MEM_READ) && (phase_q == GAP) && (beat_q == 2'd3);

    dcache_array u_array (
        .clk_i          (clock),
        .rst_n_i        (reset),
        .index_i        (idx),
        .tag_i          (tag),
        .offset_i       (address[1:0]),
        .cpu_we_i       (cpu_we),
        .cpu_wdata_i    (writedata),
        .fill_we_i      (fill_we),
        .fill_beat_i    (beat_q),
        .fill_data_i    (mem_readdata),
        .tag_we_i       (tag_we),
        .hit_o          (hit),
        .victim_dirty_o (victim_dirty),
        .victim_tag_o   (victim_tag),
        .line_o         (line)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            phase_q         <= REQ;
            beat_q          <= 2'd0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= 8'h00;
            mem_writedata_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access && !hit) begin
                        beat_q  <= 2'd0;
                        phase_q <= REQ;
                        if (victim_dirty) begin
                            state_q         <= WRITE_BACK;
                            mem_write_q     <= 1'b1;
                            mem_address_q   <= {victim_tag, idx, 2'd0};
                            mem_writedata_q <= pick_byte(line, 2'd0);
                        end else begin
                            state_q       <= MEM_READ;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= {tag, idx, 2'd0};
                        end
                    end
                end
                WRITE_BACK, MEM_READ: begin
                    if (phase_q == REQ) begin
                        if (!mem_busywait) begin
                            mem_read_q  <= 1'b0;
                            mem_write_q <= 1'b0;
                            phase_q     <= GAP;
                        end
                    end else if (beat_q != 2'd3) begin
                        beat_q  <= next_beat;
                        phase_q <= REQ;
                        if (state_q == WRITE_BACK) begin
                            mem_write_q     <= 1'b1;
                            mem_address_q   <= {victim_tag, idx, next_beat};
                            mem_writedata_q <= pick_byte(line, next_beat);
                        end else begin
                            mem_read_q    <= 1'b1;
                            mem_address_q <= {tag, idx, next_beat};
                        end
                    end else if (state_q == WRITE_BACK) begin
                        // Victim fully written back; the fill of the new line starts at once.
                        state_q       <= MEM_READ;
                        beat_q        <= 2'd0;
                        phase_q       <= REQ;
                        mem_read_q    <= 1'b1;
                        mem_address_q <= {tag, idx, 2'd0};
                    end else begin
                        state_q <= IDLE;
                        beat_q  <= 2'd0;
                        phase_q <= REQ;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: vector table of CPU accesses against a 5-cycle byte memory,
// plus a reset-in-the-middle-of-a-fill sequence.
module tb_data_cache;

    localparam int LAT = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] writedata = 8'h00;
    logic [7:0] readdata;
    logic       busywait;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_address;
    logic [7:0] mem_writedata;
    logic [7:0] mem_readdata = 8'h00;
    logic       mem_busywait;

    int checks = 0;
    int failures = 0;
    int overlap = 0;

    data_cache dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    // Byte memory: busy as soon as a request appears, done after LAT edges,
    // re-armed only once the request has been seen low at an edge.
    typedef struct {
        bit         is_wr;
        logic [7:0] a;
        logic [7:0] d;
    } op_t;

    logic [7:0] mem [256];
    op_t        log_q[$];
    int         cnt = 0;
    logic       done = 1'b0;

    assign mem_busywait = (mem_read || mem_write) && !done;

    always @(posedge clock) begin
        if (!(mem_read || mem_write)) begin
            cnt  <= 0;
            done <= 1'b0;
        end else if (!done) begin
            if (cnt == LAT - 1) begin
                done <= 1'b1;
                cnt  <= 0;
                if (mem_write) begin
                    mem[mem_address] = mem_writedata;
                    log_q.push_back('{1'b1, mem_address, mem_writedata});
                end else begin
                    mem_readdata <= mem[mem_address];
                    log_q.push_back('{1'b0, mem_address, mem[mem_address]});
                end
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (mem_read && mem_write) overlap++;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        bit         rd;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_hit;
        int         nrd;
        logic [7:0] rd_base;
        int         nwr;
        logic [7:0] wr_base;
        logic [31:0] wr_data;  // byte k of the write-back in bits [8k+7:8k]
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int         stall;
        int         nr;
        int         nw;
        logic [7:0] rdv;
        log_q.delete();
        stall = 0;
        @(posedge clock);
        #1;
        read      = v.rd;
        write     = v.wr;
        address   = v.addr;
        writedata = v.wdata;
        @(negedge clock);
        while (busywait === 1'b1 && stall < 1000) begin
            @(negedge clock);
            stall++;
        end
        chk($sformatf("%s busywait_release", tag), {31'd0, busywait}, 32'd0);
        rdv = readdata;
        @(posedge clock);
        #1;
        read  = 1'b0;
        write = 1'b0;
        chk($sformatf("%s readdata", tag), {24'd0, rdv}, {24'd0, v.exp_rdata});
        if (v.exp_hit) chk($sformatf("%s stall_cycles", tag), stall, 0);
        else           chk($sformatf("%s stalled", tag), {31'd0, stall > 0}, 32'd1);
        nr = 0;
        nw = 0;
        for (int k = 0; k < log_q.size(); k++) begin
            if (log_q[k].is_wr) begin
                if (nw < v.nwr) begin
                    chk($sformatf("%s wb%0d_addr", tag, nw), {24'd0, log_q[k].a}, {24'd0, v.wr_base + 8'(nw)});
                    chk($sformatf("%s wb%0d_data", tag, nw), {24'd0, log_q[k].d}, {24'd0, v.wr_data[8*nw +: 8]});
                end
                nw++;
            end else begin
                if (nr < v.nrd)
                    chk($sformatf("%s rd%0d_addr", tag, nr), {24'd0, log_q[k].a}, {24'd0, v.rd_base + 8'(nr)});
                nr++;
            end
        end
        chk($sformatf("%s mem_reads", tag), nr, v.nrd);
        chk($sformatf("%s mem_writes", tag), nw, v.nwr);
    endtask

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h24] = 8'h11;
        mem[8'h25] = 8'h22;
        mem[8'h26] = 8'h33;
        mem[8'h27] = 8'h44;

        //            rd    wr    addr   wdata  rdata  hit   nrd rd_base nwr wr_base wr_data
        vecs.push_back('{1'b1, 1'b0, 8'h24, 8'h00, 8'h11, 1'b0, 4, 8'h24, 0, 8'h00, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 8'h27, 8'h00, 8'h44, 1'b1, 0, 8'h00, 0, 8'h00, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 8'h25, 8'hAB, 8'h00, 1'b1, 0, 8'h00, 0, 8'h00, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 8'h25, 8'h00, 8'hAB, 1'b1, 0, 8'h00, 0, 8'h00, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 8'h44, 8'h00, 8'h1E, 1'b0, 4, 8'h44, 4, 8'h24, 32'h4433AB11});
        vecs.push_back('{1'b0, 1'b1, 8'hC8, 8'h5A, 8'h00, 1'b0, 4, 8'hC8, 0, 8'h00, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 8'hC8, 8'h00, 8'h5A, 1'b1, 0, 8'h00, 0, 8'h00, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 8'h30, 8'h77, 8'h00, 1'b1, 0, 8'h00, 0, 8'h00, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 8'h47, 8'h00, 8'h1D, 1'b1, 0, 8'h00, 0, 8'h00, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 8'h0A, 8'h00, 8'h50, 1'b0, 4, 8'h08, 4, 8'hC8, 32'h9190935A});

        #12;
        chk("reset busywait", {31'd0, busywait}, 32'd0);
        chk("reset readdata", {24'd0, readdata}, 32'd0);
        chk("reset mem_read", {31'd0, mem_read}, 32'd0);
        chk("reset mem_write", {31'd0, mem_write}, 32'd0);
        chk("reset mem_address", {24'd0, mem_address}, 32'd0);
        chk("reset mem_writedata", {24'd0, mem_writedata}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 7) chk("mem_C8_before_evict", {24'd0, mem[8'hC8]}, 32'h92);
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        chk("mem_C8_after_evict", {24'd0, mem[8'hC8]}, 32'h5A);
        chk("mem_25_after_evict", {24'd0, mem[8'h25]}, 32'hAB);

        // Reset while beat 2 of a fill is being requested.
        @(posedge clock);
        #1;
        log_q.delete();
        read    = 1'b1;
        address = 8'h60;
        t = 0;
        @(negedge clock);
        while (!(log_q.size() >= 2 && mem_read) && t < 1000) begin
            @(negedge clock);
            t++;
        end
        chk("rst_reach_beat2 reads", log_q.size(), 2);
        chk("rst_reach_beat2 mem_read", {31'd0, mem_read}, 32'd1);
        reset = 1'b0;
        read  = 1'b0;
        #1;
        chk("rst_mid mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mid busywait", {31'd0, busywait}, 32'd0);
        chk("rst_mid mem_address", {24'd0, mem_address}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        run_vec('{1'b1, 1'b0, 8'h60, 8'h00, 8'h3A, 1'b0, 4, 8'h60, 0, 8'h00, 32'h0}, "refetch60");
        run_vec('{1'b1, 1'b0, 8'h25, 8'h00, 8'hAB, 1'b0, 4, 8'h24, 0, 8'h00, 32'h0}, "refetch25");
        run_vec('{1'b1, 1'b0, 8'h27, 8'h00, 8'h44, 1'b1, 0, 8'h00, 0, 8'h00, 32'h0}, "hit27");

        chk("read_write_overlap_cycles", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
